// File: rtl/bot_updt_handler.sv
// Core-side handler for the Rojobot update strobe and status bus.
// Syncs the strobe, snapshots bot info, raises IRQ, Wishbone regs.
module bot_updt_handler #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_bot_updt,
    input  logic [31:0] i_bot_info,
    output logic [7:0]  o_motctl,
    output logic        o_irq,
    output logic        o_int_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   arm_q;
    logic                   edge_q;
    logic                   upd_evt;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] snap_q;
    logic        pending_q;
    logic        irq_en_q;
    logic [7:0]  ovr_q;

    logic        cnt_load, cnt_dec, snap_en, ovr_inc;
    logic        wb_acc, wb_wr, wb_rd;
    logic        wr_mot, wr_sts, wr_ack;
    logic        ack_wr, clr_ovr;
    logic [31:0] rd_data;
    logic [31:0] status;
    logic        unused_dat;

    // arm_q marks when the edge register holds a real post-reset sample,
    // so a strobe held high across reset release is not seen as an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            arm_q  <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_bot_updt};
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign upd_evt = arm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~edge_q;

    assign wb_acc  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wb_wr   = wb_acc & i_wb_we;
    assign wb_rd   = wb_acc & ~i_wb_we;
    assign wr_mot  = wb_wr & (i_wb_adr == 2'd1);
    assign wr_sts  = wb_wr & (i_wb_adr == 2'd2);
    assign wr_ack  = wb_wr & (i_wb_adr == 2'd3);
    assign ack_wr  = wr_ack & i_wb_dat[0];
    assign clr_ovr = wr_ack & i_wb_dat[1];

    assign unused_dat = ^i_wb_dat[31:8];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (upd_evt) state_d = CAPTURE;
            CAPTURE: if (!upd_evt && cnt_q == 4'd1) state_d = PENDING;
            PENDING: begin
                if (upd_evt)     state_d = CAPTURE;
                else if (ack_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        snap_en  = 1'b0;
        ovr_inc  = 1'b0;
        case (state_q)
            IDLE: cnt_load = upd_evt;
            CAPTURE: begin
                cnt_load = upd_evt;
                ovr_inc  = upd_evt;
                cnt_dec  = ~upd_evt;
                snap_en  = ~upd_evt & (cnt_q == 4'd1);
            end
            PENDING: begin
                cnt_load = upd_evt;
                ovr_inc  = upd_evt & ~ack_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b0;
            ovr_q     <= '0;
        end else begin
            if (cnt_load)                  cnt_q <= SETTLE_LD;
            else if (cnt_dec && cnt_q != 0) cnt_q <= cnt_q - 4'd1;
            if (snap_en) snap_q <= i_bot_info;
            if (snap_en)     pending_q <= 1'b1;
            else if (ack_wr) pending_q <= 1'b0;
            // clear beats a same-cycle overrun
            if (clr_ovr)                      ovr_q <= '0;
            else if (ovr_inc && ovr_q != '1)  ovr_q <= ovr_q + 8'd1;
        end
    end

    assign status = {16'h0, ovr_q, 4'h0, state_q, irq_en_q, pending_q};

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            i_wb_adr == 2'd0: rd_data = snap_q;
            i_wb_adr == 2'd1: rd_data = {24'h0, o_motctl};
            i_wb_adr == 2'd2: rd_data = status;
            default:          rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_motctl  <= '0;
            irq_en_q  <= 1'b0;
            o_irq     <= 1'b0;
            o_int_ack <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= '0;
        end else begin
            if (wr_mot) o_motctl <= i_wb_dat[7:0];
            if (wr_sts) irq_en_q <= i_wb_dat[1];
            o_irq     <= pending_q & irq_en_q;
            o_int_ack <= ack_wr;
            o_wb_ack  <= wb_acc;
            if (wb_rd) o_wb_rdt <= rd_data;
        end
    end

endmodule

// File: tb/tb_bot_updt_handler.sv
// Bench for bot_updt_handler: bus scoreboard plus timed update checks.
module tb_bot_updt_handler;

    localparam int SYNC   = 2;
    localparam int SETTLE = 6;
    localparam int LAT    = SYNC + SETTLE + 2;

    typedef struct {
        bit          rd;
        logic [31:0] dat;
        string       tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  wb_adr;
    logic [31:0] wb_dat;
    logic        wb_we, wb_cyc, wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        bot_updt;
    logic [31:0] bot_info;
    logic [7:0]  motctl;
    logic        irq, int_ack;

    int n_chk  = 0;
    int n_fail = 0;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    bot_updt_handler #(
        .SYNC_STAGES  (SYNC),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_wb_adr  (wb_adr),
        .i_wb_dat  (wb_dat),
        .i_wb_we   (wb_we),
        .i_wb_cyc  (wb_cyc),
        .i_wb_stb  (wb_stb),
        .o_wb_rdt  (wb_rdt),
        .o_wb_ack  (wb_ack),
        .i_bot_updt(bot_updt),
        .i_bot_info(bot_info),
        .o_motctl  (motctl),
        .o_irq     (irq),
        .o_int_ack (int_ack)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input bit rd, input logic [31:0] dat,
                           input string tag);
        sb_t e;
        e.rd  = rd;
        e.dat = dat;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] adr,
                           input logic [31:0] dat, input logic [31:0] exp,
                           input string tag);
        int n;
        sb_push(!we, exp, tag);
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_we  = we;
        wb_adr = adr;
        wb_dat = dat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_ack && n < 4);
        chk({tag, "_ack"}, wb_ack, 1);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
        wb_xfer(1'b1, adr, dat, 32'h0, "wr");
    endtask

    task automatic wb_read(input logic [1:0] adr, input logic [31:0] exp,
                           input string tag);
        wb_xfer(1'b0, adr, 32'h0, exp, tag);
    endtask

    task automatic bot_update(input logic [31:0] info);
        bot_info = info;
        bot_updt = 1'b1;
        repeat (3) @(posedge clk);
        #1 bot_updt = 1'b0;
        repeat (SETTLE + 1) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (wb_ack) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.rd) chk(e.tag, wb_rdt, e.dat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, want finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rstn     = 1'b0;
        wb_adr   = '0;
        wb_dat   = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        bot_updt = 1'b0;
        bot_info = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", irq, 0);
        chk("rst_int_ack", int_ack, 0);
        chk("rst_wb_ack", wb_ack, 0);
        chk("rst_rdt", wb_rdt, 0);
        chk("rst_motctl", motctl, 0);
        rstn = 1'b1;
        wb_read(2, 32'h0, "rst_sts");
        wb_read(0, 32'h0, "rst_botinfo");
        wb_read(1, 32'h0, "rst_motrd");

        wb_write(2, 32'h2);
        bot_info = 32'h11223344;
        bot_updt = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("irq_early", irq, 0);
        @(posedge clk);
        #1 chk("irq_rise", irq, 1);
        bot_updt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wb_read(0, 32'h11223344, "botinfo");
        wb_write(3, 32'h1);
        chk("int_ack_on", int_ack, 1);
        chk("irq_hold", irq, 1);
        @(posedge clk);
        #1;
        chk("int_ack_off", int_ack, 0);
        chk("irq_fall", irq, 0);
        wb_read(2, 32'h2, "sts_idle");

        wb_write(2, 32'h0);
        bot_update(32'hCAFEF00D);
        wb_read(2, 32'h9, "sts_masked");
        chk("irq_masked", irq, 0);
        wb_write(2, 32'h2);
        chk("irq_en_lag", irq, 0);
        @(posedge clk);
        #1 chk("irq_unmask", irq, 1);
        wb_write(3, 32'h1);

        bot_update(32'hA0A0A0A0);
        bot_info = 32'hB1B1B1B1;
        bot_updt = 1'b1;
        repeat (3) @(posedge clk);
        #1 bot_updt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bot_info = 32'hC2C2C2C2;
        bot_updt = 1'b1;
        repeat (SETTLE + 4) @(posedge clk);
        #1 bot_updt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wb_read(2, 32'h0000020B, "sts_ovr2");
        wb_read(0, 32'hC2C2C2C2, "snap_last");
        wb_write(3, 32'h2);
        chk("no_int_ack", int_ack, 0);
        wb_read(2, 32'h0000000B, "sts_ovr_clr");

        bot_info = 32'hD3D3D3D3;
        bot_updt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_write(3, 32'h1);
        chk("sim_int_ack", int_ack, 1);
        wb_read(2, 32'h6, "sts_sim_cap");
        bot_updt = 1'b0;
        repeat (SETTLE + 2) @(posedge clk);
        #1;
        wb_read(2, 32'h0000000B, "sts_sim_pend");
        wb_read(0, 32'hD3D3D3D3, "snap_sim");

        for (int i = 0; i < 300; i++) bot_update(32'(i));
        wb_read(2, 32'h0000FF0B, "sts_sat");
        wb_read(0, 32'd299, "snap_sat");

        wb_write(1, 32'h123456A5);
        chk("motctl", motctl, 8'hA5);
        wb_read(1, 32'h000000A5, "motctl_rd");
        wb_write(0, 32'hDEADBEEF);
        wb_read(0, 32'd299, "botinfo_ro");
        wb_read(3, 32'h0, "ack_rd");
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) sb_push(1'b1, 32'hA5, "held_rd");
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        wb_adr = 2'd1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 chk("held_ack", wb_ack, 32'((k % 2) == 0));
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk);
        #1;

        bot_info = 32'hE4E4E4E4;
        bot_updt = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_irq", irq, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_int_ack", int_ack, 0);
        chk("mid_rst_wb_ack", wb_ack, 0);
        chk("mid_rst_rdt", wb_rdt, 0);
        chk("mid_rst_motctl", motctl, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (SETTLE + 8) @(posedge clk);
        #1 chk("post_rst_irq", irq, 0);
        wb_read(2, 32'h0, "sts_post_rst");
        wb_read(0, 32'h0, "snap_post_rst");
        bot_updt = 1'b0;

        repeat (2) @(posedge clk);
        #1 chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
